// File: rtl/win_ctrl_pkg.sv
// Shared types and constants for the 3x3 weighted-window stream controller.
//   state_t : sequencer FSM states
//   W_NEW / W_MID / W_OLD : column weights by age inside the window
package win_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int W_NEW = 4;
  localparam int W_MID = 3;
  localparam int W_OLD = 2;

endpackage

// File: rtl/win3x3_engine.sv
// 3x3 window engine: three 3-row columns held in a shift chain, plus a
// weighted adder. Columns are weighted by age (newest, middle, oldest).
// Ports:
//   clk, rst : clock and synchronous active-high reset (clears the window)
//   en       : shift the new column in, drop the oldest
//   col_in   : {row2,row1,row0} of the incoming column
//   sum      : weighted window sum, wraps mod 2^DSIZE
module win3x3_engine
  import win_ctrl_pkg::*;
#(
  parameter int DSIZE = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3*DSIZE-1:0] col_in,
  output logic [DSIZE-1:0]   sum
);

  logic [DSIZE-1:0] win_new [3];
  logic [DSIZE-1:0] win_mid [3];
  logic [DSIZE-1:0] win_old [3];

  function automatic logic [DSIZE-1:0] col_total(input logic [DSIZE-1:0] a,
                                                 input logic [DSIZE-1:0] b,
                                                 input logic [DSIZE-1:0] c);
    return a + b + c;
  endfunction

  function automatic logic [DSIZE-1:0] weigh(input logic [DSIZE-1:0] s,
                                             input int w);
    return s * DSIZE'(w);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        win_new[i] <= '0;
        win_mid[i] <= '0;
        win_old[i] <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < 3; i++) begin
        win_old[i] <= win_mid[i];
        win_mid[i] <= win_new[i];
        win_new[i] <= col_in[i*DSIZE +: DSIZE];
      end
    end
  end

  assign sum = weigh(col_total(win_new[0], win_new[1], win_new[2]), W_NEW)
             + weigh(col_total(win_mid[0], win_mid[1], win_mid[2]), W_MID)
             + weigh(col_total(win_old[0], win_old[1], win_old[2]), W_OLD);

endmodule

// File: rtl/win_stream_ctrl.sv
// Sequencer for the 3x3 weighted-window datapath. Scans the image band by
// band, reading one 3-row column per cycle, shifting it into the window
// engine and emitting one weighted sum per complete window.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start/busy/done   : frame control (start sampled only in IDLE)
//   rd_en, rd_addr0-2 : row-memory read strobe and per-row addresses
//   rd_data           : {row2,row1,row0}, valid the cycle after rd_en
//   res_valid/ready   : result handshake; backpressure freezes the pipeline
//   res_data/row/col  : weighted sum and window origin (band, left column)
module win_stream_ctrl
  import win_ctrl_pkg::*;
#(
  parameter int DSIZE  = 10,
  parameter int COLS   = 10,
  parameter int ROWS   = 5,
  parameter int ADDR_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr0,
  output logic [ADDR_W-1:0]  rd_addr1,
  output logic [ADDR_W-1:0]  rd_addr2,
  input  logic [3*DSIZE-1:0] rd_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DSIZE-1:0]   res_data,
  output logic [ADDR_W-1:0]  res_row,
  output logic [ADDR_W-1:0]  res_col
);

  localparam logic [ADDR_W-1:0] LAST_BAND = ADDR_W'(ROWS - 3);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_RCOL = ADDR_W'(COLS - 3);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] TWO       = ADDR_W'(2);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] band_cnt, col_cnt;
  logic [ADDR_W-1:0] base_addr;

  logic              vld_p0, vld_p1, vld_p2;
  logic [ADDR_W-1:0] band_p0, col_p0;
  logic [ADDR_W-1:0] band_p1, col_p1;
  logic [ADDR_W-1:0] band_p2, col_p2;

  logic             stall;
  logic             issue;
  logic             last_issue;
  logic             last_accept;
  logic             capture;
  logic [DSIZE-1:0] win_sum;

  assign stall       = res_valid & ~res_ready;
  assign issue       = (state == RUN) & ~stall;
  assign last_issue  = issue & (band_cnt == LAST_BAND) & (col_cnt == LAST_COL);
  assign last_accept = res_valid & res_ready &
                       (res_row == LAST_BAND) & (res_col == LAST_RCOL);
  // Windows whose left edge would sit in the previous band are never full.
  assign capture     = vld_p2 & (col_p2 >= TWO);
  assign base_addr   = band_cnt * COLS_A + col_cnt;

  // The issued read is withdrawn while stalled so rd_data keeps the last word.
  assign rd_en = vld_p0 & ~stall;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_accept) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      band_cnt <= '0;
      col_cnt  <= '0;
    end else if (state == IDLE && start) begin
      band_cnt <= '0;
      col_cnt  <= '0;
    end else if (issue) begin
      if (col_cnt == LAST_COL) begin
        col_cnt  <= '0;
        band_cnt <= band_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Stage p0: issue tag and read addresses
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      band_p0  <= '0;
      col_p0   <= '0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
      rd_addr2 <= '0;
    end else if (!stall) begin
      vld_p0 <= issue;
      if (issue) begin
        band_p0  <= band_cnt;
        col_p0   <= col_cnt;
        rd_addr0 <= base_addr;
        rd_addr1 <= base_addr + COLS_A;
        rd_addr2 <= base_addr + COLS_A + COLS_A;
      end
    end
  end

  // Stage p1: rd_data present, engine shifts on this tag
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      band_p1 <= '0;
      col_p1  <= '0;
    end else if (!stall) begin
      vld_p1  <= vld_p0;
      band_p1 <= band_p0;
      col_p1  <= col_p0;
    end
  end

  win3x3_engine #(.DSIZE(DSIZE)) u_engine (
    .clk    (clk),
    .rst    (rst),
    .en     (vld_p1 & ~stall),
    .col_in (rd_data),
    .sum    (win_sum)
  );

  // Stage p2: window tag, names the newest column now inside the engine
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      band_p2 <= '0;
      col_p2  <= '0;
    end else if (!stall) begin
      vld_p2  <= vld_p1;
      band_p2 <= band_p1;
      col_p2  <= col_p1;
    end
  end

  // Output register: holds until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      res_col   <= '0;
    end else if (!stall) begin
      res_valid <= capture;
      if (capture) begin
        res_data <= win_sum;
        res_row  <= band_p2;
        res_col  <= col_p2 - TWO;
      end
    end
  end

endmodule

// File: tb/tb_win_stream_ctrl.sv
// Directed bench for win_stream_ctrl with the default geometry (10x5, 10-bit).
// Memory model: v(r,c) = r*10+c+1, i.e. the word at address a is a+1.
module tb_win_stream_ctrl;

  localparam int DSIZE  = 10;
  localparam int COLS   = 10;
  localparam int ROWS   = 5;
  localparam int ADDR_W = 7;
  localparam int NRES   = (ROWS - 2) * (COLS - 2);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               busy, done, rd_en;
  logic [ADDR_W-1:0]  rd_addr0, rd_addr1, rd_addr2;
  logic [3*DSIZE-1:0] rd_data = '0;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic [DSIZE-1:0]   res_data;
  logic [ADDR_W-1:0]  res_row, res_col;

  int n_cmp = 0;
  int n_err = 0;

  win_stream_ctrl #(.DSIZE(DSIZE), .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data(rd_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row), .res_col(res_col)
  );

  always #5 clk = ~clk;

  function automatic logic [DSIZE-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return DSIZE'(int'(a) + 1);
  endfunction

  always @(posedge clk) begin
    if (rd_en) rd_data <= {mem_word(rd_addr2), mem_word(rd_addr1), mem_word(rd_addr0)};
  end

  // Column sums over rows r..r+2 are 30r+3k+33; weighting 2/3/4 over
  // columns c..c+2 gives 270r+27c+330 before the wrap.
  function automatic logic [DSIZE-1:0] exp_sum(input int r, input int c);
    return DSIZE'((270 * r + 27 * c + 330) % 1024);
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, rd_en, res_valid} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, rd_en, res_valid});
    end
    n_cmp++;
    if ({rd_addr0, rd_addr1, rd_addr2} !== '0) begin
      n_err++; $display("FAIL reset_addr: got %0d %0d %0d want 0 0 0", rd_addr0, rd_addr1, rd_addr2);
    end
    n_cmp++;
    if ({res_data, res_row, res_col} !== '0) begin
      n_err++; $display("FAIL reset_res: got %0d %0d %0d want 0 0 0", res_data, res_row, res_col);
    end
    // rst and start together: rst wins, nothing starts
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL rst_beats_start: busy=%b want 0", busy);
    end
  endtask

  task automatic test_first_result();
    int cnt;
    do_reset();
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL busy_after_start: busy=%b want 1", busy);
    end
    cnt = 0;
    while (rd_en !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (rd_en !== 1'b1 || rd_addr0 !== 7'd0 || rd_addr1 !== 7'd10 || rd_addr2 !== 7'd20) begin
      n_err++; $display("FAIL first_read: rd_en=%b addr=%0d/%0d/%0d want 1 0/10/20",
                        rd_en, rd_addr0, rd_addr1, rd_addr2);
    end
    cnt = 0;
    while (res_valid !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (cnt != 5) begin
      n_err++; $display("FAIL first_latency: got %0d cycles want 5", cnt);
    end
    n_cmp++;
    if (res_valid !== 1'b1 || res_row !== 7'd0 || res_col !== 7'd0 || res_data !== 10'd330) begin
      n_err++; $display("FAIL first_result: got v=%b (%0d,%0d)=%0d want 1 (0,0)=330",
                        res_valid, res_row, res_col, res_data);
    end
  endtask

  task automatic test_full_frame();
    int idx;
    do_reset();
    pulse_start();
    idx = 0;
    for (int n = 0; n < 400 && idx < NRES; n++) begin
      @(negedge clk);
      start = (n == 15);  // start while busy is ignored
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        n_cmp++;
        if (res_row !== ADDR_W'(idx / 8) || res_col !== ADDR_W'(idx % 8) ||
            res_data !== exp_sum(idx / 8, idx % 8)) begin
          n_err++; $display("FAIL frame_seq[%0d]: got (%0d,%0d)=%0d want (%0d,%0d)=%0d", idx,
                            res_row, res_col, res_data, idx / 8, idx % 8, exp_sum(idx / 8, idx % 8));
        end
        if (idx == 8) begin
          n_cmp++;
          if (res_row !== 7'd1 || res_col !== 7'd0 || res_data !== 10'd600) begin
            n_err++; $display("FAIL band_boundary: got (%0d,%0d)=%0d want (1,0)=600",
                              res_row, res_col, res_data);
          end
        end
        if (idx == NRES - 1) begin
          n_cmp++;
          if (res_row !== 7'd2 || res_col !== 7'd7 || res_data !== 10'd35) begin
            n_err++; $display("FAIL overflow_wrap: got (%0d,%0d)=%0d want (2,7)=35",
                              res_row, res_col, res_data);
          end
        end
        idx++;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (idx != NRES) begin
      n_err++; $display("FAIL frame_count: got %0d results want %0d", idx, NRES);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: done=%b busy=%b res_valid=%b want 1 0 0",
                        done, busy, res_valid);
    end
    start = 1'b1;  // start during DONE is ignored
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL after_done: done=%b busy=%b want 0 0", done, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      n_err++; $display("FAIL start_in_done_ignored: busy=%b rd_en=%b want 0 0", busy, rd_en);
    end
  endtask

  task automatic test_stall();
    int  idx;
    bit  stalled;
    do_reset();
    pulse_start();
    idx = 0;
    stalled = 1'b0;
    for (int n = 0; n < 400 && idx < NRES; n++) begin
      @(negedge clk);
      if (idx == 3 && res_valid === 1'b1 && !stalled) begin
        res_ready = 1'b0;
        stalled = 1'b1;
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          n_cmp++;
          if (res_valid !== 1'b1 || rd_en !== 1'b0 || res_row !== 7'd0 ||
              res_col !== 7'd3 || res_data !== 10'd411) begin
            n_err++; $display("FAIL stall_hold[%0d]: v=%b rd_en=%b (%0d,%0d)=%0d want 1 0 (0,3)=411",
                              s, res_valid, rd_en, res_row, res_col, res_data);
          end
        end
        res_ready = 1'b1;
      end
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        n_cmp++;
        if (res_row !== ADDR_W'(idx / 8) || res_col !== ADDR_W'(idx % 8) ||
            res_data !== exp_sum(idx / 8, idx % 8)) begin
          n_err++; $display("FAIL stall_seq[%0d]: got (%0d,%0d)=%0d want (%0d,%0d)=%0d", idx,
                            res_row, res_col, res_data, idx / 8, idx % 8, exp_sum(idx / 8, idx % 8));
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx != NRES || !stalled) begin
      n_err++; $display("FAIL stall_count: got %0d results (stalled=%0d) want %0d", idx, stalled, NRES);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL stall_done: done=%b want 1", done);
    end
  endtask

  task automatic test_reset_midframe();
    int cnt;
    do_reset();
    pulse_start();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, rd_en, res_valid} !== 4'b0000 ||
        {rd_addr0, rd_addr1, rd_addr2, res_data, res_row, res_col} !== '0) begin
      n_err++; $display("FAIL midframe_reset: ctrl=%b addr=%0d/%0d/%0d res=(%0d,%0d)=%0d want all 0",
                        {busy, done, rd_en, res_valid}, rd_addr0, rd_addr1, rd_addr2,
                        res_row, res_col, res_data);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      n_err++; $display("FAIL midframe_idle: busy=%b rd_en=%b want 0 0", busy, rd_en);
    end
    pulse_start();
    cnt = 0;
    while (res_valid !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (res_valid !== 1'b1 || res_row !== 7'd0 || res_col !== 7'd0 || res_data !== 10'd330) begin
      n_err++; $display("FAIL restart_first: got v=%b (%0d,%0d)=%0d want 1 (0,0)=330",
                        res_valid, res_row, res_col, res_data);
    end
  endtask

  initial begin
    test_reset();
    test_first_result();
    test_full_frame();
    test_stall();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
